// File: rtl/lsu_mem_port.sv
// Load/store port between the core's execute stage and a word-wide data memory.
// Sub-word stores go through a read-modify-write pass because the memory only writes whole words.
module lsu_mem_port #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW,
        STORE,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [1:0]  cap_lane;
    logic [31:0] cap_wdata;

    logic        req_err;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign req_err = (req_size == 2'd3)
                  || (req_size == 2'd1 && req_addr[0])
                  || (req_size == 2'd2 && req_addr[1:0] != 2'b00);

    assign shamt   = {cap_lane, 3'b000};
    assign shifted = mem_rdata >> shamt;

    always_comb begin
        load_data = mem_rdata;
        case (cap_size)
            2'd0:    load_data = cap_unsigned ? {24'd0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = cap_unsigned ? {16'd0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    assign lane_mask = ((cap_size == 2'd0) ? 32'h0000_00ff : 32'h0000_ffff) << shamt;
    assign merged    = (mem_rdata & ~lane_mask) | ((cap_wdata << shamt) & lane_mask);

    // NOTE: reset gates these combinationally so a write in flight is suppressed in the reset cycle itself.
    assign req_ready = (state == IDLE)  && !rst;
    assign mem_we    = (state == STORE) && !rst;
    assign rsp_valid = (state == RESP);

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cap_size     <= 2'd0;
            cap_unsigned <= 1'b0;
            cap_lane     <= 2'd0;
            cap_wdata    <= 32'd0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_lane     <= req_addr[1:0];
                        cap_wdata    <= req_wdata;
                        rsp_rdata    <= 32'd0;
                        if (req_err) begin
                            rsp_err <= 1'b1;
                            state   <= RESP;
                        end else begin
                            rsp_err   <= 1'b0;
                            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            // Word stores write req_wdata directly; RMW overwrites this with the merge.
                            mem_wdata <= req_we ? req_wdata : 32'd0;
                            if (!req_we)
                                state <= LOAD;
                            else if (req_size == 2'd2)
                                state <= STORE;
                            else
                                state <= RMW;
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata <= load_data;
                    mem_addr  <= '0;
                    state     <= RESP;
                end
                RMW: begin
                    mem_wdata <= merged;
                    state     <= STORE;
                end
                STORE: begin
                    mem_addr  <= '0;
                    mem_wdata <= 32'd0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-array reference model, bench-side word memory,
// one per-cycle compare process plus directed literal checks and random traffic.
module tb_lsu_mem_port;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_we;

    lsu_mem_port #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory the DUT drives.
    logic [31:0] bmem [64];
    assign mem_rdata = bmem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) bmem[mem_addr[7:2]] <= mem_wdata;

    // Reference model: flat little-endian byte array.
    logic [7:0] gold [256];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_err(input logic [1:0] s, input logic [7:0] a);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] s, input logic u, input logic [7:0] a);
        int nb = 1 << s;
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nb; i++)
            v |= 32'(gold[a + 8'(i)]) << (8 * i);
        if (nb < 4 && !u && v[8*nb-1])
            v |= ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] gword(input logic [5:0] w);
        return {gold[{w, 2'd3}], gold[{w, 2'd2}], gold[{w, 2'd1}], gold[{w, 2'd0}]};
    endfunction

    // Expectations for the transaction in flight, set at the accepting edge.
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_maddr;
    int          we_cnt;
    bit          mon_en = 1'b0;
    logic [1:0]  cur_sz;
    logic [7:0]  cur_a;
    logic [31:0] cur_wd;
    int          cur_lat;
    bit          cur_store;

    // Compare process: checks bus and response outputs on every falling edge.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            check("mem_addr_align", 32'(mem_addr[1:0]), 32'd0);
            if (rsp_valid) begin
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                check("req_ready_busy", 32'(req_ready), 32'd0);
            end
            if (mem_we) begin
                we_cnt++;
                check("mem_addr_write", 32'(mem_addr), 32'(exp_maddr));
            end
            if (req_ready)
                check("idle_mem_bus", 32'({mem_we, mem_addr}), 32'd0);
        end
    end

    task automatic start_req(input logic we, input logic [1:0] sz, input logic un,
                             input logic [7:0] a, input logic [31:0] wd);
        int n = 0;
        req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        exp_err   = m_err(sz, a);
        exp_rdata = (we || exp_err) ? 32'd0 : m_load(sz, un, a);
        exp_maddr = {a[7:2], 2'b00};
        cur_sz = sz; cur_a = a; cur_wd = wd;
        cur_store = we && !exp_err;
        cur_lat   = exp_err ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3));
        we_cnt    = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic finish_req(input int hold, input bit poke,
                              output logic [31:0] rd, output logic er);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 20);
        check("latency", 32'(cyc), 32'(cur_lat));
        if (poke) begin
            // A competing store that must not be accepted while the response is pending.
            req_we = 1'b1; req_size = 2'd2; req_addr = 8'h00; req_wdata = 32'd0;
            req_valid = 1'b1;
        end
        repeat (hold) @(negedge clk);
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_taken", 32'(rsp_valid), 32'd0);
        if (poke) begin
            check("ready_after_handoff", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end
        check("mem_we_count", 32'(we_cnt), cur_store ? 32'd1 : 32'd0);
        if (cur_store)
            for (int i = 0; i < (1 << cur_sz); i++)
                gold[cur_a + 8'(i)] = cur_wd[8*i +: 8];
        check("mem_word", bmem[cur_a[7:2]], gword(cur_a[7:2]));
    endtask

    task automatic txn(input logic we, input logic [1:0] sz, input logic un, input logic [7:0] a,
                       input logic [31:0] wd, input int hold, input bit poke,
                       output logic [31:0] rd, output logic er);
        start_req(we, sz, un, a, wd);
        finish_req(hold, poke, rd, er);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        for (int i = 0; i < 64; i++) bmem[i] = 32'd0;
        for (int i = 0; i < 256; i++) gold[i] = 8'd0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 32'd0; rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_mem_bus", 32'({mem_we, mem_addr}), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 32'd1);

        txn(1'b1, 2'd2, 1'b0, 8'h00, 32'hdeadbeef, 0, 1'b0, rd, er);
        txn(1'b0, 2'd2, 1'b0, 8'h00, 32'd0, 0, 1'b0, rd, er);
        check("lit_load_word0", rd, 32'hdeadbeef);
        check("lit_load_word0_err", 32'(er), 32'd0);

        txn(1'b1, 2'd2, 1'b0, 8'h04, 32'hcafebabe, 0, 1'b0, rd, er);
        txn(1'b1, 2'd0, 1'b0, 8'h05, 32'h000000ab, 0, 1'b0, rd, er);
        check("lit_rmw_byte_word", bmem[1], 32'hcafeabbe);
        txn(1'b0, 2'd0, 1'b0, 8'h05, 32'd0, 0, 1'b0, rd, er);
        check("lit_lb_signed", rd, 32'hffffffab);
        txn(1'b0, 2'd0, 1'b1, 8'h05, 32'd0, 0, 1'b0, rd, er);
        check("lit_lb_unsigned", rd, 32'h000000ab);

        txn(1'b1, 2'd2, 1'b0, 8'h08, 32'h12345678, 0, 1'b0, rd, er);
        txn(1'b1, 2'd1, 1'b0, 8'h0a, 32'h00008001, 0, 1'b0, rd, er);
        check("lit_rmw_half_word", bmem[2], 32'h80015678);
        txn(1'b0, 2'd1, 1'b0, 8'h0a, 32'd0, 0, 1'b0, rd, er);
        check("lit_lh_signed", rd, 32'hffff8001);
        txn(1'b0, 2'd1, 1'b1, 8'h0a, 32'd0, 0, 1'b0, rd, er);
        check("lit_lh_unsigned", rd, 32'h00008001);
        txn(1'b0, 2'd0, 1'b0, 8'h08, 32'd0, 0, 1'b0, rd, er);
        check("lit_lb_lane0", rd, 32'h00000078);

        txn(1'b1, 2'd2, 1'b0, 8'h02, 32'h11111111, 0, 1'b0, rd, er);
        check("lit_misaligned_store_err", 32'(er), 32'd1);
        txn(1'b0, 2'd2, 1'b0, 8'h00, 32'd0, 0, 1'b0, rd, er);
        check("lit_word0_intact", rd, 32'hdeadbeef);
        txn(1'b0, 2'd1, 1'b0, 8'h03, 32'd0, 0, 1'b0, rd, er);
        check("lit_misaligned_half_err", 32'(er), 32'd1);
        check("lit_misaligned_half_rdata", rd, 32'd0);
        txn(1'b0, 2'd3, 1'b0, 8'h00, 32'd0, 0, 1'b0, rd, er);
        check("lit_illegal_size_err", 32'(er), 32'd1);
        check("lit_illegal_size_rdata", rd, 32'd0);

        // Backpressure with a competing request held on the request channel.
        txn(1'b0, 2'd2, 1'b0, 8'h00, 32'd0, 3, 1'b1, rd, er);
        check("lit_held_load", rd, 32'hdeadbeef);
        check("lit_word0_after_poke", bmem[0], 32'hdeadbeef);

        // Reset during the STORE cycle of a byte store.
        start_req(1'b1, 2'd0, 1'b0, 8'h04, 32'h00000055);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_store_we", 32'(mem_we), 32'd0);
        check("reset_store_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_word_intact", bmem[1], 32'hcafeabbe);
        check("abort_model_word", bmem[1], gword(6'd1));

        for (int n = 0; n < 200; n++) begin
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 2)), 1'b0, rd, er);
        end

        for (int w = 0; w < 16; w++)
            check("final_mem_word", bmem[w], gword(6'(w)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
